// File: rtl/instruction_fetch_stage_if.sv
// Bus bundle between the fetch stage, its instruction ROM and the ID-stage decoder.
// The master side is the fetch stage; the slave side is the ROM/decoder environment.
interface instruction_fetch_stage_if #(
    parameter int IMEM_ADDR_W = 10
);
    logic                   ID_stall;
    logic                   redirect_valid;
    logic [31:0]            redirect_target;
    logic [IMEM_ADDR_W-1:0] imem_addr;
    logic [31:0]            imem_data;
    logic [31:0]            IF_ID_Instruction;
    logic [31:0]            IF_ID_PCPlus4;
    logic                   IF_ID_valid;

    modport master (
        input  ID_stall, redirect_valid, redirect_target, imem_data,
        output imem_addr, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_valid
    );

    modport slave (
        output ID_stall, redirect_valid, redirect_target, imem_data,
        input  imem_addr, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_valid
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// IF stage with IF/ID register: owns the PC, fetches from a combinational ROM,
// holds on ID stall, redirects on ID-resolved branches/jumps, counts fetch/stall/flush.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 10,
    parameter int          DELAY_SLOT  = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    instruction_fetch_stage_if.master bus,
    output logic [31:0] PC_out,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;
    ifid_t       ifid;

    assign pc_plus4       = pc + 32'd4;
    assign target_aligned = bus.redirect_target & ~32'h3;

    // ROM address comes straight from the registered PC only.
    assign bus.imem_addr         = pc[IMEM_ADDR_W+1:2];
    assign bus.IF_ID_Instruction = ifid.instr;
    assign bus.IF_ID_PCPlus4     = ifid.pc_plus4;
    assign bus.IF_ID_valid       = ifid.valid;
    assign PC_out                = pc;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc          <= RESET_PC;
            ifid        <= '0;
            fetch_count <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else if (bus.ID_stall) begin
            // Instruction in ID has not issued, so any redirect this cycle is not yet real.
            stall_count <= stall_count + 32'd1;
        end else if (bus.redirect_valid) begin
            pc <= target_aligned;
            if (DELAY_SLOT != 0) begin
                ifid        <= '{instr: bus.imem_data, pc_plus4: pc_plus4, valid: 1'b1};
                fetch_count <= fetch_count + 32'd1;
            end else begin
                ifid        <= '0;
                flush_count <= flush_count + 32'd1;
            end
        end else begin
            pc          <= pc_plus4;
            ifid        <= '{instr: bus.imem_data, pc_plus4: pc_plus4, valid: 1'b1};
            fetch_count <= fetch_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Runs a DELAY_SLOT=0 and a DELAY_SLOT=1 fetch stage side by side on shared stimulus,
// comparing both against a rule-level model of PC, IF/ID contents and counters.
module tb_instruction_fetch_stage;
    localparam int AW = 10;

    logic        Clk;
    logic        rst, stall, rv;
    logic [31:0] rt;
    logic [31:0] rom [0:(1<<AW)-1];

    logic [31:0] pc_o0, fc0, sc0, flc0;
    logic [31:0] pc_o1, fc1, sc1, flc1;

    instruction_fetch_stage_if #(.IMEM_ADDR_W(AW)) if0 ();
    instruction_fetch_stage_if #(.IMEM_ADDR_W(AW)) if1 ();

    assign if0.ID_stall        = stall;
    assign if0.redirect_valid  = rv;
    assign if0.redirect_target = rt;
    assign if0.imem_data       = rom[if0.imem_addr];
    assign if1.ID_stall        = stall;
    assign if1.redirect_valid  = rv;
    assign if1.redirect_target = rt;
    assign if1.imem_data       = rom[if1.imem_addr];

    instruction_fetch_stage #(.RESET_PC(32'h0), .IMEM_ADDR_W(AW), .DELAY_SLOT(0)) dut0 (
        .Clk(Clk), .Reset(rst), .bus(if0.master), .PC_out(pc_o0),
        .fetch_count(fc0), .stall_count(sc0), .flush_count(flc0)
    );
    instruction_fetch_stage #(.RESET_PC(32'h0), .IMEM_ADDR_W(AW), .DELAY_SLOT(1)) dut1 (
        .Clk(Clk), .Reset(rst), .bus(if1.master), .PC_out(pc_o1),
        .fetch_count(fc1), .stall_count(sc1), .flush_count(flc1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state, index = DELAY_SLOT setting
    logic [31:0] m_pc [2];
    logic [31:0] m_ins[2];
    logic [31:0] m_p4 [2];
    logic        m_v  [2];
    logic [31:0] m_fc [2];
    logic [31:0] m_sc [2];
    logic [31:0] m_flc[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom_at(input logic [31:0] byte_addr);
        logic [AW-1:0] w;
        w = byte_addr[AW+1:2];
        return rom[w];
    endfunction

    task automatic check_dut(input int d, input logic [31:0] pco, input logic [31:0] ins,
                             input logic [31:0] p4, input logic v, input logic [31:0] fc,
                             input logic [31:0] sc, input logic [31:0] flc,
                             input logic [AW-1:0] ia);
        logic [31:0] ia_exp;
        ia_exp = {22'd0, m_pc[d][AW+1:2]};
        chk($sformatf("ds%0d_pc", d),    pco, m_pc[d]);
        chk($sformatf("ds%0d_ins", d),   ins, m_ins[d]);
        chk($sformatf("ds%0d_p4", d),    p4,  m_p4[d]);
        chk($sformatf("ds%0d_valid", d), {31'd0, v}, {31'd0, m_v[d]});
        chk($sformatf("ds%0d_fetch", d), fc,  m_fc[d]);
        chk($sformatf("ds%0d_stall", d), sc,  m_sc[d]);
        chk($sformatf("ds%0d_flush", d), flc, m_flc[d]);
        chk($sformatf("ds%0d_iaddr", d), {22'd0, ia}, ia_exp);
    endtask

    // Apply one cycle of inputs, advance the model by the rules, check after the edge.
    task automatic step(input logic r, input logic s, input logic v, input logic [31:0] t);
        rst = r; stall = s; rv = v; rt = t;
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                m_pc[d] = 32'h0; m_ins[d] = 0; m_p4[d] = 0; m_v[d] = 0;
                m_fc[d] = 0; m_sc[d] = 0; m_flc[d] = 0;
            end else if (s) begin
                m_sc[d] = m_sc[d] + 1;
            end else if (v) begin
                if (d == 1) begin
                    m_ins[d] = rom_at(m_pc[d]); m_p4[d] = m_pc[d] + 4; m_v[d] = 1;
                    m_fc[d] = m_fc[d] + 1;
                end else begin
                    m_ins[d] = 0; m_p4[d] = 0; m_v[d] = 0;
                    m_flc[d] = m_flc[d] + 1;
                end
                m_pc[d] = {t[31:2], 2'b00};
            end else begin
                m_ins[d] = rom_at(m_pc[d]); m_p4[d] = m_pc[d] + 4; m_v[d] = 1;
                m_fc[d] = m_fc[d] + 1;
                m_pc[d] = m_pc[d] + 4;
            end
        end
        @(posedge Clk);
        #1;
        check_dut(0, pc_o0, if0.IF_ID_Instruction, if0.IF_ID_PCPlus4, if0.IF_ID_valid,
                  fc0, sc0, flc0, if0.imem_addr);
        check_dut(1, pc_o1, if1.IF_ID_Instruction, if1.IF_ID_PCPlus4, if1.IF_ID_valid,
                  fc1, sc1, flc1, if1.imem_addr);
        @(negedge Clk);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = 32'h2000_0000 + i;
        rst = 1'b1; stall = 1'b0; rv = 1'b0; rt = 32'h0;
        @(negedge Clk);

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_valid", {31'd0, if0.IF_ID_valid}, 32'd0);
        // Three sequential fetches after release
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("tp_ins3", if0.IF_ID_Instruction, 32'h2000_0002);
        chk("tp_p4_3", if0.IF_ID_PCPlus4, 32'd12);
        chk("tp_fc3",  fc0, 32'd3);
        // Redirect to 0x40 at PC=12
        step(0, 0, 1, 32'h40);
        chk("tp_rd_pc0",  pc_o0, 32'h40);
        chk("tp_rd_flc0", flc0, 32'd1);
        chk("tp_rd_ins1", if1.IF_ID_Instruction, 32'h2000_0003);
        chk("tp_rd_flc1", flc1, 32'd0);
        step(0, 0, 0, 0);
        chk("tp_after_ins0", if0.IF_ID_Instruction, 32'h2000_0010);
        chk("tp_after_p40",  if0.IF_ID_PCPlus4, 32'h44);
        // Stall for 3 cycles, with a redirect presented during it
        step(0, 1, 0, 0);
        step(0, 1, 1, 32'h100);
        step(0, 1, 1, 32'h100);
        chk("tp_stall_sc", sc0, 32'd3);
        chk("tp_stall_pc", pc_o0, 32'h44);
        step(0, 0, 0, 0);
        // Misaligned redirect, then back-to-back redirects
        step(0, 0, 1, 32'h43);
        chk("tp_align_pc", pc_o0, 32'h40);
        step(0, 0, 1, 32'h200);
        step(0, 0, 1, 32'h300);
        step(0, 0, 0, 0);
        // PC wrap at the top of the address space
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("tp_wrap_pc", pc_o0, 32'h0);
        step(0, 0, 0, 0);
        // Reset during a stall with a pending redirect
        step(0, 1, 1, 32'h80);
        step(1, 1, 1, 32'h80);
        chk("tp_rst_fc", fc1, 32'd0);

        for (int n = 0; n < 1500; n++) begin
            logic r, s, v;
            logic [31:0] t;
            r = ($urandom % 64) == 0;
            s = ($urandom % 4) == 0;
            v = ($urandom % 5) == 0;
            t = (($urandom % 8) == 0) ? $urandom : ($urandom % 32'h2000);
            step(r, s, v, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
